find_first_one_idx: RTL and testbench

- Priority encoder: returns the index of the least-significant set bit of an N-bit vector, plus a valid flag.
- Used by the adapter's arbitration and slot-selection logic to choose the lowest free or requesting entry.
- Primary result is purely combinational (zero latency).
- A registered copy of the result is also provided for timing-critical consumers; it is the only use of clock and reset.

---
 rtl/find_first_one_idx_pkg.sv | 9 +
 rtl/find_first_one_idx_node.sv | 23 ++
 rtl/find_first_one_idx.sv | 73 +++++++
 tb/tb_find_first_one_idx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/find_first_one_idx_pkg.sv
// find_first_one_idx_pkg: width helper shared by the priority-encoder tree.
package find_first_one_idx_pkg;

    // Index width for an n-bit search; a single-bit vector still gets a 1-bit index.
    function automatic int ffo_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/find_first_one_idx_node.sv
// find_first_one_idx_node: merges two (valid, idx) pairs, lower half wins.
module find_first_one_idx_node #(
    parameter int CW = 0
) (
    input  logic                      i_lo_v,
    input  logic [(CW>0?CW:1)-1:0]    i_lo_idx,
    input  logic                      i_hi_v,
    input  logic [(CW>0?CW:1)-1:0]    i_hi_idx,
    output logic                      o_v,
    output logic [CW:0]               o_idx
);

    assign o_v = i_lo_v | i_hi_v;

    if (CW == 0) begin : g_leaf
        logic w_unused;
        assign w_unused = ^{i_lo_idx, i_hi_idx};
        assign o_idx    = ~i_lo_v;
    end else begin : g_inner
        assign o_idx = {~i_lo_v, i_lo_v ? i_lo_idx : i_hi_idx};
    end

endmodule

// File: rtl/find_first_one_idx.sv
// find_first_one_idx: index of the least-significant set bit, combinational
// and registered one cycle later.
module find_first_one_idx
    import find_first_one_idx_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = ffo_idx_w(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_q_o,
    output logic             valid_q_o
);

    localparam int PW = 1 << IDX_W;

    logic [PW-1:0]    w_pad;
    logic             w_root_v;
    logic [IDX_W-1:0] w_root_idx;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;

    // Zero padding up to a power of two; padding bits can never be selected.
    assign w_pad = PW'(in_i);

    genvar l, k;
    for (l = 0; l <= IDX_W; l++) begin : g_lvl
        localparam int NN = 1 << (IDX_W - l);
        logic                  w_v   [NN];
        logic [(l>0?l:1)-1:0]  w_idx [NN];
        if (l == 0) begin : g_leaf
            for (k = 0; k < NN; k++) begin : g_k
                assign w_v[k]   = w_pad[k];
                assign w_idx[k] = 1'b0;
            end
        end else begin : g_tree
            for (k = 0; k < NN; k++) begin : g_k
                find_first_one_idx_node #(.CW(l - 1)) u_node (
                    .i_lo_v   (g_lvl[l-1].w_v[2*k]),
                    .i_lo_idx (g_lvl[l-1].w_idx[2*k]),
                    .i_hi_v   (g_lvl[l-1].w_v[2*k+1]),
                    .i_hi_idx (g_lvl[l-1].w_idx[2*k+1]),
                    .o_v      (w_v[k]),
                    .o_idx    (w_idx[k])
                );
            end
        end
    end

    assign w_root_v   = g_lvl[IDX_W].w_v[0];
    assign w_root_idx = g_lvl[IDX_W].w_idx[0];

    // An empty tree reports all-ones internally; force the defined zero index.
    assign idx_o   = w_root_v ? w_root_idx : '0;
    assign valid_o = w_root_v;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= idx_o;
            r_valid <= valid_o;
        end
    end

    assign idx_q_o   = r_idx;
    assign valid_q_o = r_valid;

endmodule

// File: tb/tb_find_first_one_idx.sv
// tb_find_first_one_idx: directed and random checks of the lowest-set-bit encoder
// across several widths, plus the registered path and reset.
module tb_find_first_one_idx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:0]  in1;  logic [0:0] idx1, idxq1;  logic v1, vq1;
    logic [1:0]  in2;  logic [0:0] idx2, idxq2;  logic v2, vq2;
    logic [2:0]  in3;  logic [1:0] idx3, idxq3;  logic v3, vq3;
    logic [4:0]  in5;  logic [2:0] idx5, idxq5;  logic v5, vq5;
    logic [6:0]  in7;  logic [2:0] idx7, idxq7;  logic v7, vq7;
    logic [7:0]  in8;  logic [2:0] idx8, idxq8;  logic v8, vq8;
    logic [32:0] in33; logic [5:0] idx33, idxq33; logic v33, vq33;

    find_first_one_idx #(.N(1))  u_n1  (.clk_i(clk), .rst_i(rst), .in_i(in1),  .idx_o(idx1),  .valid_o(v1),  .idx_q_o(idxq1),  .valid_q_o(vq1));
    find_first_one_idx #(.N(2))  u_n2  (.clk_i(clk), .rst_i(rst), .in_i(in2),  .idx_o(idx2),  .valid_o(v2),  .idx_q_o(idxq2),  .valid_q_o(vq2));
    find_first_one_idx #(.N(3))  u_n3  (.clk_i(clk), .rst_i(rst), .in_i(in3),  .idx_o(idx3),  .valid_o(v3),  .idx_q_o(idxq3),  .valid_q_o(vq3));
    find_first_one_idx #(.N(5))  u_n5  (.clk_i(clk), .rst_i(rst), .in_i(in5),  .idx_o(idx5),  .valid_o(v5),  .idx_q_o(idxq5),  .valid_q_o(vq5));
    find_first_one_idx #(.N(7))  u_n7  (.clk_i(clk), .rst_i(rst), .in_i(in7),  .idx_o(idx7),  .valid_o(v7),  .idx_q_o(idxq7),  .valid_q_o(vq7));
    find_first_one_idx #(.N(8))  u_n8  (.clk_i(clk), .rst_i(rst), .in_i(in8),  .idx_o(idx8),  .valid_o(v8),  .idx_q_o(idxq8),  .valid_q_o(vq8));
    find_first_one_idx #(.N(33)) u_n33 (.clk_i(clk), .rst_i(rst), .in_i(in33), .idx_o(idx33), .valid_o(v33), .idx_q_o(idxq33), .valid_q_o(vq33));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Linear-scan reference: lowest set bit, 0 when empty.
    function automatic int lsb(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin
        in1 = '0; in2 = '0; in3 = '0; in5 = '0; in7 = '0; in33 = '0;
        in8 = 8'hFF;
        // Registered path and reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_idx_q", int'(idxq8), 0);
        check("rst_valid_q", int'(vq8), 0);
        @(negedge clk);
        rst = 1'b0;
        in8 = 8'b0100_0000;
        #1;
        check("pre_edge_valid_q", int'(vq8), 0);
        @(posedge clk); #1;
        check("q_idx_6", int'(idxq8), 6);
        check("q_valid_6", int'(vq8), 1);
        @(negedge clk);
        in8 = 8'b1000_0000;
        #1;
        check("q_hold_6", int'(idxq8), 6);
        @(posedge clk); #1;
        check("q_idx_7", int'(idxq8), 7);
        @(negedge clk);
        in8 = 8'b0100_0000;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_idx_q", int'(idxq8), 0);
        check("mid_rst_valid_q", int'(vq8), 0);
        check("mid_rst_idx_o", int'(idx8), 6);
        check("mid_rst_valid_o", int'(v8), 1);
        @(negedge clk);
        rst = 1'b0;

        // Directed combinational vectors
        in3 = 3'b000; #1;
        check("n3_zero_valid", int'(v3), 0);
        check("n3_zero_idx", int'(idx3), 0);
        for (int i = 0; i < 3; i++) begin
            in3 = 3'(1 << i); #1;
            check($sformatf("n3_onehot%0d_idx", i), int'(idx3), i);
            check($sformatf("n3_onehot%0d_valid", i), int'(v3), 1);
        end
        for (int i = 0; i < 8; i++) begin
            in8 = 8'(1 << i); #1;
            check($sformatf("n8_onehot%0d_idx", i), int'(idx8), i);
            check($sformatf("n8_onehot%0d_valid", i), int'(v8), 1);
        end
        in3 = 3'b111; in8 = 8'hFF; #1;
        check("n3_ones_idx", int'(idx3), 0);
        check("n8_ones_idx", int'(idx8), 0);
        in3 = 3'b101; in8 = 8'b1000_0001; #1;
        check("n3_ends_idx", int'(idx3), 0);
        check("n8_ends_idx", int'(idx8), 0);
        in8 = 8'b1011_0100; #1;
        check("n8_b4_idx", int'(idx8), 2);
        in8 = 8'b0000_0000; #1;
        check("n8_zero_valid", int'(v8), 0);
        check("n8_zero_idx", int'(idx8), 0);
        in1 = 1'b1; #1;
        check("n1_one_valid", int'(v1), 1);
        check("n1_one_idx", int'(idx1), 0);
        in1 = 1'b0; #1;
        check("n1_zero_valid", int'(v1), 0);
        check("n1_zero_idx", int'(idx1), 0);
        in5 = 5'b10000; #1;
        check("n5_top_idx", int'(idx5), 4);
        check("n5_top_valid", int'(v5), 1);
        in5 = 5'b00000; #1;
        check("n5_zero_idx", int'(idx5), 0);
        in7 = 7'b100_0000; #1;
        check("n7_top_idx", int'(idx7), 6);
        in33 = 33'h1_0000_0000; #1;
        check("n33_top_idx", int'(idx33), 32);
        check("n33_top_valid", int'(v33), 1);

        // Random vectors, sparse on odd iterations to reach high indices
        for (int r = 0; r < 120; r++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = (r % 2) ? (a & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : a;
            if (r % 10 == 3) b = '0;
            in2 = b[1:0]; in3 = b[2:0]; in7 = b[6:0]; in8 = b[7:0]; in33 = b[32:0];
            #1;
            check($sformatf("rnd%0d_n2_idx", r),  int'(idx2),  lsb({62'b0, in2}));
            check($sformatf("rnd%0d_n2_v", r),    int'(v2),    int'(|in2));
            check($sformatf("rnd%0d_n3_idx", r),  int'(idx3),  lsb({61'b0, in3}));
            check($sformatf("rnd%0d_n3_v", r),    int'(v3),    int'(|in3));
            check($sformatf("rnd%0d_n7_idx", r),  int'(idx7),  lsb({57'b0, in7}));
            check($sformatf("rnd%0d_n7_v", r),    int'(v7),    int'(|in7));
            check($sformatf("rnd%0d_n8_idx", r),  int'(idx8),  lsb({56'b0, in8}));
            check($sformatf("rnd%0d_n8_v", r),    int'(v8),    int'(|in8));
            check($sformatf("rnd%0d_n33_idx", r), int'(idx33), lsb({31'b0, in33}));
            check($sformatf("rnd%0d_n33_v", r),   int'(v33),   int'(|in33));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
